// File: rtl/latch_wr_arbiter.sv
// -----------------------------------------------------------------------------
// latch_wr_arbiter
//
// Round-robin write controller that shares one WIDTH-bit bank of gated D
// latches among NREQ requesters. Each granted transfer runs through three
// timed phases:
//   SETUP  - data is placed on lat_d and allowed to settle
//   ENABLE - the registered, glitch-free lat_e pulse opens the latches
//   HOLD   - data is kept stable after lat_e falls
// One IDLE cycle always separates consecutive transfers.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   req      per-requester write request (level, only sampled in IDLE)
//   data_in  requester i data at bits [i*WIDTH +: WIDTH]
//   gnt      one-hot grant, held for the whole transfer
//   done     one-cycle completion pulse during the final HOLD cycle
//   lat_d    data to the latch bank d inputs
//   lat_e    enable to the latch bank e input
//   busy     high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module latch_wr_arbiter #(
    parameter int NREQ         = 4,
    parameter int WIDTH        = 8,
    parameter int SETUP_CYCLES = 1,
    parameter int EN_CYCLES    = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   data_in,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic [WIDTH-1:0]        lat_d,
    output logic                    lat_e,
    output logic                    busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Each phase counter is loaded with (cycles - 1) on entry and the phase
    // ends on the edge where the counter reads zero.
    localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] EN_LOAD    = 8'(EN_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYCLES - 1);

    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ENABLE,
        HOLD
    } state_t;

    state_t             state;
    logic [7:0]         cnt;
    logic [PTR_W-1:0]   ptr;

    logic               sel_valid;
    logic [PTR_W-1:0]   sel_idx;
    logic [PTR_W-1:0]   sel_next;
    logic [PTR_W-1:0]   cand;
    logic [WIDTH-1:0]   slice [NREQ];
    logic [WIDTH-1:0]   sel_data;

    // Split the flat data bus into one word per requester so the winner can
    // be selected with a narrow index.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            slice[k] = data_in[k*WIDTH +: WIDTH];
        end
    end

    // Round-robin search: scan upward from the pointer with wrap and keep
    // the first requester found. sel_next is the pointer value that gives
    // the requester after the winner top priority next time.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_next  = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PTR_W'((int'(ptr) + k) % NREQ);
            if (!sel_valid && req[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
                sel_next  = PTR_W'((int'(ptr) + k + 1) % NREQ);
            end
        end
        sel_data = slice[sel_idx];
    end

    // Transfer sequencer. Every output is a flop, so lat_e cannot glitch,
    // and the asynchronous reset drops lat_e and gnt immediately without
    // ever producing a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= '0;
            gnt   <= '0;
            done  <= '0;
            lat_d <= '0;
            lat_e <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        gnt   <= ONE_HOT0 << sel_idx;
                        lat_d <= sel_data;
                        ptr   <= sel_next;
                        cnt   <= SETUP_LOAD;
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end

                SETUP: begin
                    if (cnt == 8'd0) begin
                        lat_e <= 1'b1;
                        cnt   <= EN_LOAD;
                        state <= ENABLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                ENABLE: begin
                    if (cnt == 8'd0) begin
                        lat_e <= 1'b0;
                        cnt   <= HOLD_LOAD;
                        state <= HOLD;
                        // A one-cycle hold phase is also its final cycle.
                        if (HOLD_LOAD == 8'd0) begin
                            done <= gnt;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                HOLD: begin
                    if (cnt == 8'd0) begin
                        gnt   <= '0;
                        done  <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                        // Entering the last hold cycle.
                        if (cnt == 8'd1) begin
                            done <= gnt;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_latch_wr_arbiter
//
// Directed bench for latch_wr_arbiter. Two instances share clock and reset:
// dut uses the default timing (S=1, E=2, H=1) and dut6 uses S=3, E=1, H=2.
// A behavioural D latch on each lat_d/lat_e pair stands in for the bank.
// -----------------------------------------------------------------------------
module tb_latch_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk;
    logic                  rst;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data_in;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      lat_d;
    logic                  lat_e;
    logic                  busy;

    logic [NREQ-1:0]       req6;
    logic [NREQ*WIDTH-1:0] data6;
    logic [NREQ-1:0]       gnt6;
    logic [NREQ-1:0]       done6;
    logic [WIDTH-1:0]      lat_d6;
    logic                  lat_e6;
    logic                  busy6;

    logic [WIDTH-1:0]      lat_q;
    logic [WIDTH-1:0]      lat_q6;

    int nvec;
    int nerr;

    latch_wr_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH),
        .SETUP_CYCLES(1), .EN_CYCLES(2), .HOLD_CYCLES(1)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in),
        .gnt(gnt), .done(done), .lat_d(lat_d), .lat_e(lat_e), .busy(busy)
    );

    latch_wr_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH),
        .SETUP_CYCLES(3), .EN_CYCLES(1), .HOLD_CYCLES(2)
    ) dut6 (
        .clk(clk), .rst(rst), .req(req6), .data_in(data6),
        .gnt(gnt6), .done(done6), .lat_d(lat_d6), .lat_e(lat_e6), .busy(busy6)
    );

    // Clock: period 10, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transparent-high D latch models of the shared bank.
    always @(lat_e or lat_d) begin
        if (lat_e) lat_q = lat_d;
    end

    always @(lat_e6 or lat_d6) begin
        if (lat_e6) lat_q6 = lat_d6;
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        req     = '0;
        data_in = '0;
        req6    = '0;
        data6   = '0;
        #2;
        nvec++;
        if (gnt !== 4'b0000 || done !== 4'b0000) begin
            $display("[TB] FAIL reset_gnt_done: gnt=%b done=%b, want 0000/0000", gnt, done);
            nerr++;
        end
        nvec++;
        if (lat_d !== 8'h00 || lat_e !== 1'b0 || busy !== 1'b0) begin
            $display("[TB] FAIL reset_lat_busy: lat_d=%h lat_e=%b busy=%b, want 00/0/0", lat_d, lat_e, busy);
            nerr++;
        end
        nvec++;
        if (gnt6 !== 4'b0000 || lat_e6 !== 1'b0 || busy6 !== 1'b0) begin
            $display("[TB] FAIL reset_dut6: gnt=%b lat_e=%b busy=%b, want 0000/0/0", gnt6, lat_e6, busy6);
            nerr++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [3:0] exp_e;
        logic [3:0] exp_done;
        exp_e    = 4'b0110;
        exp_done = 4'b1000;
        data_in  = {8'h00, 8'h00, 8'hA5, 8'h00};
        req      = 4'b0010;
        step();
        req = 4'b0000;
        nvec++;
        if (gnt !== 4'b0010 || lat_d !== 8'hA5) begin
            $display("[TB] FAIL single_grant: gnt=%b lat_d=%h, want 0010/a5", gnt, lat_d);
            nerr++;
        end
        for (int c = 0; c < 4; c++) begin
            nvec++;
            if (lat_e !== exp_e[c] || done !== (exp_done[c] ? 4'b0010 : 4'b0000) ||
                gnt !== 4'b0010 || busy !== 1'b1) begin
                $display("[TB] FAIL single_cycle%0d: lat_e=%b done=%b gnt=%b busy=%b, want lat_e=%b done[1]=%b gnt=0010 busy=1",
                         c, lat_e, done, gnt, busy, exp_e[c], exp_done[c]);
                nerr++;
            end
            if (c < 3) step();
        end
        step();
        nvec++;
        if (gnt !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 || lat_q !== 8'hA5) begin
            $display("[TB] FAIL single_end: gnt=%b done=%b busy=%b q=%h, want 0000/0000/0/a5", gnt, done, busy, lat_q);
            nerr++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_dat [4];
        exp_dat = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        data_in = {8'h44, 8'h33, 8'h22, 8'h11};
        req     = 4'b1111;
        for (int t = 0; t < 4; t++) begin
            step();
            nvec++;
            if (gnt !== (4'b0001 << t) || lat_d !== exp_dat[t]) begin
                $display("[TB] FAIL rr_grant%0d: gnt=%b lat_d=%h, want %b/%h", t, gnt, lat_d, 4'b0001 << t, exp_dat[t]);
                nerr++;
            end
            for (int c = 0; c < 4; c++) begin
                step();
                nvec++;
                if ($countones(gnt) > 1) begin
                    $display("[TB] FAIL rr_onehot: gnt=%b, want at most one bit", gnt);
                    nerr++;
                end
            end
            nvec++;
            if (lat_q !== exp_dat[t] || gnt !== 4'b0000) begin
                $display("[TB] FAIL rr_latch%0d: q=%h gnt=%b, want %h/0000", t, lat_q, gnt, exp_dat[t]);
                nerr++;
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_alternate();
        logic [3:0] exp_g [4];
        exp_g = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        do_reset();
        data_in = {8'h44, 8'h33, 8'h22, 8'h11};
        req     = 4'b0101;
        for (int t = 0; t < 4; t++) begin
            step();
            nvec++;
            if (gnt !== exp_g[t]) begin
                $display("[TB] FAIL alt_grant%0d: gnt=%b, want %b", t, gnt, exp_g[t]);
                nerr++;
            end
            for (int c = 0; c < 4; c++) step();
        end
        req = 4'b0000;
    endtask

    task automatic test_pulse_req();
        do_reset();
        data_in = {8'h5A, 8'h00, 8'h00, 8'h00};
        req     = 4'b1000;
        step();
        req = 4'b0000;
        nvec++;
        if (gnt !== 4'b1000 || lat_d !== 8'h5A) begin
            $display("[TB] FAIL pulse_grant: gnt=%b lat_d=%h, want 1000/5a", gnt, lat_d);
            nerr++;
        end
        step();
        data_in = {8'hFF, 8'h00, 8'h00, 8'h00};
        step();
        nvec++;
        if (lat_e !== 1'b1 || lat_d !== 8'h5A) begin
            $display("[TB] FAIL pulse_enable: lat_e=%b lat_d=%h, want 1/5a", lat_e, lat_d);
            nerr++;
        end
        step();
        nvec++;
        if (done !== 4'b1000 || lat_d !== 8'h5A) begin
            $display("[TB] FAIL pulse_done: done=%b lat_d=%h, want 1000/5a", done, lat_d);
            nerr++;
        end
        for (int c = 0; c < 4; c++) begin
            step();
            nvec++;
            if (gnt !== 4'b0000 || busy !== 1'b0) begin
                $display("[TB] FAIL pulse_nogrant%0d: gnt=%b busy=%b, want 0000/0", c, gnt, busy);
                nerr++;
            end
        end
        nvec++;
        if (lat_q !== 8'h5A || lat_d !== 8'h5A) begin
            $display("[TB] FAIL pulse_latch: q=%h lat_d=%h, want 5a/5a", lat_q, lat_d);
            nerr++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        data_in = {8'h44, 8'h33, 8'h22, 8'h11};
        req     = 4'b0010;
        step();
        req = 4'b0000;
        step();
        nvec++;
        if (lat_e !== 1'b1 || gnt !== 4'b0010) begin
            $display("[TB] FAIL areset_pre: lat_e=%b gnt=%b, want 1/0010", lat_e, gnt);
            nerr++;
        end
        #2;
        rst = 1'b1;
        #1;
        nvec++;
        if (lat_e !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000 || lat_d !== 8'h00) begin
            $display("[TB] FAIL areset_drop: lat_e=%b gnt=%b busy=%b done=%b lat_d=%h, want 0/0000/0/0000/00",
                     lat_e, gnt, busy, done, lat_d);
            nerr++;
        end
        #3;
        rst = 1'b0;
        req = 4'b1001;
        step();
        req = 4'b0000;
        nvec++;
        if (gnt !== 4'b0001 || lat_d !== 8'h11) begin
            $display("[TB] FAIL areset_regrant: gnt=%b lat_d=%h, want 0001/11", gnt, lat_d);
            nerr++;
        end
        for (int c = 0; c < 4; c++) step();
    endtask

    task automatic test_params();
        logic [5:0] exp_e;
        logic [5:0] exp_done;
        exp_e    = 6'b001000;
        exp_done = 6'b100000;
        data6    = {8'h00, 8'h00, 8'h00, 8'h3C};
        req6     = 4'b0001;
        step();
        req6 = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            nvec++;
            if (lat_e6 !== exp_e[c] || done6 !== (exp_done[c] ? 4'b0001 : 4'b0000) ||
                gnt6 !== 4'b0001 || busy6 !== 1'b1) begin
                $display("[TB] FAIL param_cycle%0d: lat_e=%b done=%b gnt=%b busy=%b, want lat_e=%b done[0]=%b gnt=0001 busy=1",
                         c, lat_e6, done6, gnt6, busy6, exp_e[c], exp_done[c]);
                nerr++;
            end
            step();
        end
        nvec++;
        if (busy6 !== 1'b0 || gnt6 !== 4'b0000 || done6 !== 4'b0000 || lat_q6 !== 8'h3C) begin
            $display("[TB] FAIL param_end: busy=%b gnt=%b done=%b q=%h, want 0/0000/0000/3c", busy6, gnt6, done6, lat_q6);
            nerr++;
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_alternate();
        test_pulse_req();
        test_async_reset();
        test_params();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/latch_wr_arbiter.md
Name: latch_wr_arbiter

Overview:
- Round-robin write controller that shares one WIDTH-bit bank of gated D latches among NREQ requesters.
- Each granted transfer is sequenced as data setup, then a registered glitch-free latch-enable pulse, then data hold.
- Sits between requester logic and the latch bank; lat_d and lat_e drive the bank's d and e inputs directly.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, latch bank data width
SETUP_CYCLES, 1, cycles lat_d is stable before lat_e rises (1..255)
EN_CYCLES, 2, cycles lat_e is held high (1..255)
HOLD_CYCLES, 1, cycles lat_d is stable after lat_e falls (1..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
req  input  NREQ  per-requester write request, level
data_in  input  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot grant, held for the whole transfer
done  output  NREQ  one-cycle completion pulse to the granted requester
lat_d  output  WIDTH  data to latch bank
lat_e  output  1  latch enable to latch bank
busy  output  1  high when state != IDLE

Behaviour:
- Single clock domain. Reset is asynchronous and active-high on rst.
- Reset values: state IDLE; gnt, done, lat_d, lat_e all 0; busy 0; RR pointer set so requester 0 has highest priority.
- All outputs are registered. lat_e must never glitch.
- FSM states: IDLE, SETUP, ENABLE, HOLD. One down-counter, 8 bits wide, is loaded on each state entry.
- IDLE: req sampled. If req==0, stay. Otherwise grant the first set req bit scanning upward (with wrap) from the pointer. On that edge:
  - gnt[i]=1.
  - lat_d is loaded with data_in slice i.
  - pointer becomes (i+1) mod NREQ.
  - Go to SETUP.
- SETUP: lasts SETUP_CYCLES cycles, lat_e=0, then go to ENABLE.
- ENABLE: lat_e=1 for exactly EN_CYCLES cycles, then go to HOLD.
- HOLD: lat_e=0 for HOLD_CYCLES cycles. done[i]=1 during the final HOLD cycle only. Next edge: IDLE, gnt=0, done=0.
- Timing: with grant at edge k, lat_e rises at edge k+S and falls at edge k+S+E. IDLE is re-entered at edge k+S+E+H. Transfer length is S+E+H cycles plus a mandatory 1 IDLE cycle between transfers.
- lat_d is captured once at grant and held constant until the next grant. data_in changes mid-transfer are ignored.
- req is not sampled outside IDLE:
  - Dropping req mid-transfer does not abort; done still pulses.
  - A req still high at the IDLE cycle after done is a new request, arbitrated with the updated pointer.
- Simultaneous requests: exactly one grant. Fairness is strict round-robin, so no requester waits more than NREQ-1 transfers.
- Pointer wrap: after granting NREQ-1 the pointer returns to 0.
- Reset mid-operation (any state): lat_e and gnt drop immediately (asynchronously). No done is issued. lat_d is cleared to 0 and the pointer is reset.
- gnt is never multi-hot. done is never asserted without the matching gnt.

Test Plan:
1. Defaults, req=0010, data_in slice1=0xA5 → gnt=0010 at next edge; lat_d=0xA5 same edge; lat_e high 2 cycles starting 1 cycle later; done[1] high 1 cycle during the 4th grant cycle; a D-latch model on lat_d/lat_e holds q=0xA5 afterwards.
2. req=1111 held with distinct data 0x11/0x22/0x33/0x44 → grants in order 0,1,2,3, each 5 cycles apart; latch model sequence 0x11,0x22,0x33,0x44; gnt always one-hot.
3. req=0101 held continuously → grants alternate 0,2,0,2; neither requester is starved.
4. req[3] pulsed for 1 cycle only, and data_in slice3 changed from 0x5A to 0xFF during ENABLE → transfer completes with lat_d=0x5A throughout; done[3] pulses; no second grant.
5. rst asserted asynchronously in the middle of ENABLE → lat_e=0 and gnt=0 before the next clk edge; busy=0; no done; the first grant after release goes to requester 0 when req=1001.
6. Parameters S=3, E=1, H=2 → lat_e high exactly 1 cycle, 3 cycles after grant; done in the 6th grant cycle; busy high for 6 cycles.
